// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready access port with a programmable
// response latency; illegal addresses complete with err instead of touching the RAM.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [21:0] addr,
  input  logic [21:0] wdata,
  output logic [21:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err,
  output logic [1:0]  state_dbg
);

  // Handshake: a request is taken on any rising edge where req=1 and the
  // block is in IDLE or RESP; it is completed by a single-cycle ready strobe
  // (with err qualifying it). req is ignored while WAIT is in progress.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [20:0] DEPTH_L  = 21'(DEPTH_WORDS);
  localparam logic [3:0] WAIT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]    state;
  logic [3:0]    wait_cnt;
  logic          we_q;
  logic [21:0]   addr_q;
  logic [21:0]   wdata_q;
  logic [19:0]   word_idx;
  logic [AW-1:0] mem_idx;
  logic          illegal;
  logic          accept;

  logic [21:0] mem [DEPTH_WORDS];

  assign word_idx = addr_q[21:2];
  assign mem_idx  = word_idx[AW-1:0];
  // Full 20-bit compare so out-of-range indices never alias onto real words.
  assign illegal  = (addr_q[1:0] != 2'b00) || ({1'b0, word_idx} >= DEPTH_L);
  assign accept   = req && ((state == S_IDLE) || (state == S_RESP));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= 22'd0;
      wdata_q  <= 22'd0;
    end else if (accept) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      if (LATENCY == 0) begin
        state <= S_RESP;
      end else begin
        state    <= S_WAIT;
        wait_cnt <= WAIT_LOAD;
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 4'd0) state <= S_RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The write lands on the edge leaving RESP, so a back-to-back read sees it.
  always_ff @(posedge clk) begin
    if ((state == S_RESP) && we_q && !illegal) begin
      mem[mem_idx] <= wdata_q;
    end
  end

  assign ready     = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign err       = ready && illegal;
  assign rdata     = (ready && !we_q && !illegal) ? mem[mem_idx] : 22'd0;
  assign state_dbg = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 0, 2, 15) share one input
// bus; each scenario checks only the instance it targets.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [21:0] addr;
  logic [21:0] wdata;

  logic [2:0][21:0] rdata_v;
  logic [2:0]       ready_v;
  logic [2:0]       busy_v;
  logic [2:0]       err_v;
  logic [2:0][1:0]  st_v;

  int checks = 0;
  int errors = 0;

  logic [21:0] exp_q[$];
  logic [21:0] mem_model [64];

  typedef struct {
    bit          w;
    logic [21:0] a;
    logic [21:0] d;
    bit          exp_err;
    logic [21:0] exp_rd;
  } vec_t;

  vec_t vt [12];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .err(err_v[0]),
    .state_dbg(st_v[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .err(err_v[1]),
    .state_dbg(st_v[1])
  );

  mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .err(err_v[2]),
    .state_dbg(st_v[2])
  );

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic present(input bit w, input logic [21:0] a, input logic [21:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with a request presented; returns edges from accept
  // (accept edge = 1) until ready is seen, and busy cycles seen meanwhile.
  task automatic finish_access(input int sel, output int lat, output int bn,
                               output logic [21:0] rd, output logic er);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    lat = 1;
    bn  = 0;
    forever begin
      if (busy_v[sel]) bn++;
      if (ready_v[sel] || lat >= 40) break;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    rd = rdata_v[sel];
    er = err_v[sel];
  endtask

  task automatic access(input int sel, input bit w, input logic [21:0] a, input logic [21:0] d,
                        output int lat, output int bn, output logic [21:0] rd, output logic er);
    @(negedge clk);
    present(w, a, d);
    finish_access(sel, lat, bn, rd, er);
  endtask

  // ---------------- test sequence ----------------
  initial begin : main
    int          lat, bn, nrdy;
    logic [21:0] rd;
    logic        er;

    rst = 1'b0; req = 1'b0; we = 1'b0; addr = 22'd0; wdata = 22'd0;

    vt[0]  = '{1'b1, 22'h000010, 22'h2AAAAA, 1'b0, 22'h000000};
    vt[1]  = '{1'b0, 22'h000010, 22'h000000, 1'b0, 22'h2AAAAA};
    vt[2]  = '{1'b1, 22'h000000, 22'h0ABCDE, 1'b0, 22'h000000};
    vt[3]  = '{1'b1, 22'h000400, 22'h155555, 1'b1, 22'h000000};
    vt[4]  = '{1'b0, 22'h000000, 22'h000000, 1'b0, 22'h0ABCDE};
    vt[5]  = '{1'b0, 22'h000006, 22'h000000, 1'b1, 22'h000000};
    vt[6]  = '{1'b0, 22'h000400, 22'h000000, 1'b1, 22'h000000};
    vt[7]  = '{1'b1, 22'h0003FC, 22'h3FFFFF, 1'b0, 22'h000000};
    vt[8]  = '{1'b0, 22'h0003FC, 22'h000000, 1'b0, 22'h3FFFFF};
    vt[9]  = '{1'b1, 22'h000011, 22'h000111, 1'b1, 22'h000000};
    vt[10] = '{1'b0, 22'h000010, 22'h000000, 1'b0, 22'h2AAAAA};
    vt[11] = '{1'b0, 22'h3FFFFC, 22'h000000, 1'b1, 22'h000000};

    // Reset values while rst is held low
    #12;
    for (int s = 0; s < 3; s++) begin
      check("reset_ready", 32'(ready_v[s]), 32'd0);
      check("reset_busy",  32'(busy_v[s]),  32'd0);
      check("reset_err",   32'(err_v[s]),   32'd0);
      check("reset_rdata", 32'(rdata_v[s]), 32'd0);
      check("reset_state", 32'(st_v[s]),    32'd0);
    end

    // Request present on the very first edge after release
    @(negedge clk);
    rst = 1'b1;
    present(1'b1, 22'h000100, 22'h0C0FFE);
    finish_access(1, lat, bn, rd, er);
    check("first_edge_lat", 32'(lat), 32'd3);
    access(1, 1'b0, 22'h000100, 22'd0, lat, bn, rd, er);
    check("first_edge_rd", 32'(rd), 32'h0C0FFE);

    // Table-driven accesses on the LATENCY=2 instance
    for (int i = 0; i < 12; i++) begin
      access(1, vt[i].w, vt[i].a, vt[i].d, lat, bn, rd, er);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vt[i].exp_err));
      if (!vt[i].w) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vt[i].exp_rd));
      @(negedge clk);
      check($sformatf("vec%0d_ready_drop", i), 32'(ready_v[1]), 32'd0);
      check($sformatf("vec%0d_idle_rdata", i), 32'(rdata_v[1]), 32'd0);
      check($sformatf("vec%0d_idle_err", i), 32'(err_v[1]), 32'd0);
    end

    // req pulsed during WAIT with another address is ignored
    access(1, 1'b1, 22'h000044, 22'h011111, lat, bn, rd, er);
    @(negedge clk);
    present(1'b1, 22'h000040, 22'h022222);
    @(posedge clk);
    @(negedge clk);
    present(1'b1, 22'h000044, 22'h3BAD00);
    @(posedge clk);
    @(negedge clk);
    check("wait_pulse_no_early_ready", 32'(ready_v[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("wait_pulse_orig_ready", 32'(ready_v[1]), 32'd1);
    req = 1'b0;
    nrdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready_v[1]) nrdy++;
    end
    check("wait_pulse_extra_ready", 32'(nrdy), 32'd0);
    access(1, 1'b0, 22'h000040, 22'd0, lat, bn, rd, er);
    check("wait_pulse_orig_data", 32'(rd), 32'h022222);
    access(1, 1'b0, 22'h000044, 22'd0, lat, bn, rd, er);
    check("wait_pulse_other_data", 32'(rd), 32'h011111);

    // Write then back-to-back read of the same word (LATENCY=2)
    @(negedge clk);
    present(1'b1, 22'h000048, 22'h2F00F5);
    finish_access(1, lat, bn, rd, er);
    present(1'b0, 22'h000048, 22'd0);
    finish_access(1, lat, bn, rd, er);
    check("b2b_lat", 32'(lat), 32'd3);
    check("b2b_rdata", 32'(rd), 32'h2F00F5);
    check("b2b_err", 32'(er), 32'd0);

    // LATENCY=0 with req held for four alternating write/read ops
    idle(20);
    present(1'b1, 22'h000080, 22'h13579B);
    @(posedge clk); @(negedge clk);
    check("lat0_op0_ready", 32'(ready_v[0]), 32'd1);
    check("lat0_op0_err", 32'(err_v[0]), 32'd0);
    present(1'b0, 22'h000080, 22'd0);
    @(posedge clk); @(negedge clk);
    check("lat0_op1_ready", 32'(ready_v[0]), 32'd1);
    check("lat0_op1_rdata", 32'(rdata_v[0]), 32'h13579B);
    present(1'b1, 22'h000084, 22'h2468AC);
    @(posedge clk); @(negedge clk);
    check("lat0_op2_ready", 32'(ready_v[0]), 32'd1);
    present(1'b0, 22'h000084, 22'd0);
    @(posedge clk); @(negedge clk);
    check("lat0_op3_ready", 32'(ready_v[0]), 32'd1);
    check("lat0_op3_rdata", 32'(rdata_v[0]), 32'h2468AC);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("lat0_end_ready", 32'(ready_v[0]), 32'd0);
    check("lat0_end_busy", 32'(busy_v[0]), 32'd0);

    // Reset asserted during WAIT of a write aborts it
    idle(20);
    access(1, 1'b1, 22'h000020, 22'h0D1D1D, lat, bn, rd, er);
    @(negedge clk);
    present(1'b1, 22'h000020, 22'h3E3E3E);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    check("abort_in_wait", 32'(st_v[1]), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", 32'(ready_v[1]), 32'd0);
    check("abort_busy", 32'(busy_v[1]), 32'd0);
    check("abort_err", 32'(err_v[1]), 32'd0);
    check("abort_rdata", 32'(rdata_v[1]), 32'd0);
    check("abort_state", 32'(st_v[1]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    nrdy = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready_v[1]) nrdy++;
    end
    check("abort_no_ready", 32'(nrdy), 32'd0);
    access(1, 1'b0, 22'h000020, 22'd0, lat, bn, rd, er);
    check("abort_old_data", 32'(rd), 32'h0D1D1D);
    check("ram_kept_over_reset", 32'(rdata_v[1]), 32'h0D1D1D);

    // LATENCY=15
    idle(20);
    access(2, 1'b1, 22'h000030, 22'h000123, lat, bn, rd, er);
    check("lat15_wr_lat", 32'(lat), 32'd16);
    check("lat15_wr_busy", 32'(bn), 32'd16);
    @(negedge clk);
    check("lat15_busy_drop", 32'(busy_v[2]), 32'd0);
    access(2, 1'b0, 22'h000030, 22'd0, lat, bn, rd, er);
    check("lat15_rd_lat", 32'(lat), 32'd16);
    check("lat15_rd_data", 32'(rd), 32'h000123);

    // Randomized accesses on LATENCY=2 vs. a word-array reference model
    idle(20);
    for (int k = 0; k < 64; k++) begin
      mem_model[k] = 22'($urandom);
      access(1, 1'b1, 22'(k * 4), mem_model[k], lat, bn, rd, er);
      check("fill_lat", 32'(lat), 32'd3);
    end
    for (int n = 0; n < 150; n++) begin
      int          kind, idx;
      bit          w, bad;
      logic [21:0] a, d, exp_rd;
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 63);
      w    = 1'($urandom_range(0, 1));
      d    = 22'($urandom);
      if (kind < 2)       a = 22'((idx * 4) + $urandom_range(1, 3));
      else if (kind == 2) a = 22'((256 + idx) * 4);
      else if (kind == 3) a = 22'h3FFFFC;
      else                a = 22'(idx * 4);
      bad = (a % 4 != 0) || ((a / 4) >= 256);
      exp_rd = (bad || w) ? 22'd0 : mem_model[a / 4];
      if (!w) exp_q.push_back(exp_rd);
      if ($urandom_range(0, 2) != 0) begin
        @(posedge clk);
        @(negedge clk);
      end
      present(w, a, d);
      finish_access(1, lat, bn, rd, er);
      check("rand_lat", 32'(lat), 32'd3);
      check("rand_err", 32'(er), 32'(bad));
      if (!w) check("rand_rdata", 32'(rd), 32'(exp_q.pop_front()));
      if (w && !bad) mem_model[a / 4] = d;
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 22-bit data words stored.
REQ-002 The module SHALL have parameter LATENCY, default 2, meaning the wait cycles between request accept and response; legal range 0..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port req, input, 1 bit: the processor requests an access this cycle.
REQ-006 The module SHALL have port we, input, 1 bit: 1 = write, 0 = read; sampled with req.
REQ-007 The module SHALL have port addr, input, 22 bits: byte address; word index = addr[21:2].
REQ-008 The module SHALL have port wdata, input, 22 bits: write data; sampled with req.
REQ-009 The module SHALL have port rdata, output, 22 bits: read data; valid only while ready=1 for a read.
REQ-010 The module SHALL have port ready, output, 1 bit: one-cycle response strobe completing the accepted access.
REQ-011 The module SHALL have port busy, output, 1 bit: high while an access is in progress (WAIT or RESP).
REQ-012 The module SHALL have port err, output, 1 bit: qualifies ready; the access was rejected.

Function
REQ-013 The module SHALL implement FSM states IDLE, WAIT, RESP, with IDLE as the reset state.
REQ-014 In IDLE with req=1, the module SHALL latch we, addr and wdata into internal registers and go to WAIT, or go directly to RESP when LATENCY=0.
REQ-015 In IDLE with req=0, the module SHALL remain in IDLE with no state change.
REQ-016 On entering WAIT, the module SHALL load a 4-bit wait counter with LATENCY-1, decrement it each cycle, and go to RESP in the cycle after it reads 0, so that ready rises exactly LATENCY+1 cycles after the accepting edge.
REQ-017 In RESP, the module SHALL assert ready=1 for exactly one cycle.
REQ-018 For a legal write, the RAM word SHALL update on the clock edge that leaves RESP.
REQ-019 For a legal read, rdata SHALL equal the stored word at the latched index during the RESP cycle.
REQ-020 When ready=0, rdata SHALL be 0.
REQ-021 An access SHALL be illegal when the latched addr[1:0]!=0 or addr[21:2]>=DEPTH_WORDS.
REQ-022 An illegal access SHALL assert err=1 together with ready, perform no write, and drive rdata=0.
REQ-023 err SHALL be 0 whenever ready=0.
REQ-024 In RESP with req=1, the module SHALL accept the new request (back-to-back) with the same latching and next-state rules as IDLE; otherwise it SHALL return to IDLE.
REQ-025 In WAIT, the module SHALL ignore req, we, addr and wdata, and SHALL not queue requests.
REQ-026 A write followed back-to-back by a read of the same word SHALL return the newly written data.
REQ-027 busy SHALL equal (state!=IDLE).
REQ-028 For word-index arithmetic, the module SHALL use unsigned 20-bit compare against DEPTH_WORDS, with no address wrap-around.

Reset
REQ-029 When rst=0, the module SHALL immediately (asynchronously) force state=IDLE, wait counter=0, latched registers=0, ready=0, err=0, busy=0 and rdata=0.
REQ-030 Reset asserted mid-access SHALL abort the access, with no RAM write and no ready pulse after release.
REQ-031 RAM contents SHALL NOT be cleared by reset.
REQ-032 On the first rising edge after rst returns to 1, req SHALL be sampled normally.

Verification
REQ-033 Bench: with LATENCY=2, write addr=0x000010, wdata=0x2AAAAA, then read 0x000010 -> ready pulses 3 cycles after each accept, and the read returns rdata=0x2AAAAA with err=0.
REQ-034 Bench: with LATENCY=0, req held high for 4 alternating write/read ops -> ready high every cycle after the first accept, and each read returns the prior write.
REQ-035 Bench: read addr=0x000006 (misaligned) and addr=0x000400 (index 256 >= DEPTH) -> ready=1, err=1, rdata=0, and RAM unchanged.
REQ-036 Bench: pulse req during WAIT with a different addr -> pulse is ignored, and only the original access responds.
REQ-037 Bench: assert rst=0 during WAIT of a write to 0x000020 -> outputs 0 immediately, no ready pulse, and a later read of 0x000020 returns the old data.
REQ-038 Bench: with LATENCY=15 -> ready rises exactly 16 cycles after accept, and busy stays high for 16 cycles.
